// File: rtl/prog_ctr.sv
// Program counter / instruction-fetch address generator.
// Idles after reset, launches from START_ADDR when Start is released, then steps or branches.
module prog_ctr #(
    parameter int PC_WIDTH   = 10,
    parameter int START_ADDR = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic                BranchAbsEn,
    input  logic                BranchRelEn,
    input  logic                ALU_flag,
    input  logic [PC_WIDTH-1:0] Target,
    output logic [PC_WIDTH-1:0] ProgCtr
);

    localparam logic [PC_WIDTH-1:0] LAUNCH_PC = PC_WIDTH'(START_ADDR);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [PC_WIDTH-1:0] r_progCtr;
    logic [PC_WIDTH-1:0] w_nextPc;

    // Reset wins over everything, including a running program.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_progCtr <= '0;
        end else begin
            r_state   <= w_nextState;
            r_progCtr <= w_nextPc;
        end
    end

    // Sums are PC_WIDTH wide, so relative offsets wrap modulo 2^PC_WIDTH.
    always_comb begin
        w_nextState = r_state;
        w_nextPc    = r_progCtr;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_nextState = ARMED;
                end
            end
            ARMED: begin
                if (!Start) begin
                    w_nextState = RUN;
                    w_nextPc    = LAUNCH_PC;
                end
            end
            RUN: begin
                if (Start) begin
                    w_nextState = ARMED;
                end else if (BranchAbsEn) begin
                    w_nextPc = Target;
                end else if (BranchRelEn && ALU_flag) begin
                    w_nextPc = r_progCtr + Target;
                end else begin
                    w_nextPc = r_progCtr + PC_WIDTH'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign ProgCtr = r_progCtr;

endmodule

// File: tb/tb_prog_ctr.sv
// Directed self-checking bench for prog_ctr with hand-computed expected addresses.
module tb_prog_ctr;

    localparam int PC_WIDTH = 10;

    logic                Clk;
    logic                Reset;
    logic                Start;
    logic                BranchAbsEn;
    logic                BranchRelEn;
    logic                ALU_flag;
    logic [PC_WIDTH-1:0] Target;
    logic [PC_WIDTH-1:0] ProgCtr;

    int checks = 0;
    int errors = 0;

    prog_ctr #(
        .PC_WIDTH  (PC_WIDTH),
        .START_ADDR(0)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .BranchAbsEn(BranchAbsEn),
        .BranchRelEn(BranchRelEn),
        .ALU_flag   (ALU_flag),
        .Target     (Target),
        .ProgCtr    (ProgCtr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one cycle's inputs, let the edge happen, then settle 1 time unit past it.
    task automatic applyStimulus(input logic rst, input logic st, input logic absEn,
                                 input logic relEn, input logic flag,
                                 input logic [PC_WIDTH-1:0] tgt);
        Reset       = rst;
        Start       = st;
        BranchAbsEn = absEn;
        BranchRelEn = relEn;
        ALU_flag    = flag;
        Target      = tgt;
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [PC_WIDTH-1:0] expected);
        checks++;
        assert (ProgCtr === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed ProgCtr=%0d expected %0d", tag, ProgCtr, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 10'd0);     checkOutput("reset", 10'd0);
        applyStimulus(0, 0, 0, 0, 0, 10'd0);     checkOutput("idle_hold", 10'd0);
        applyStimulus(0, 0, 1, 0, 0, 10'd9);     checkOutput("idle_branch_ignored", 10'd0);
        applyStimulus(0, 1, 0, 0, 0, 10'd0);     checkOutput("armed", 10'd0);
        applyStimulus(0, 1, 1, 0, 0, 10'd9);     checkOutput("armed_branch_ignored", 10'd0);
        applyStimulus(0, 0, 0, 0, 0, 10'd0);     checkOutput("launch", 10'd0);
        applyStimulus(0, 0, 0, 0, 0, 10'd0);     checkOutput("first_step", 10'd1);
        applyStimulus(0, 0, 1, 0, 0, 10'd10);    checkOutput("abs_branch", 10'd10);
        applyStimulus(0, 0, 0, 1, 0, 10'd5);     checkOutput("rel_not_taken", 10'd11);
        applyStimulus(0, 0, 0, 1, 1, 10'd5);     checkOutput("rel_taken", 10'd16);
        applyStimulus(0, 0, 0, 1, 1, 10'h3FE);   checkOutput("rel_negative", 10'd14);
        applyStimulus(0, 0, 1, 0, 1, 10'd1023);  checkOutput("abs_to_top", 10'd1023);
        applyStimulus(0, 0, 0, 0, 0, 10'd0);     checkOutput("wrap_increment", 10'd0);
        applyStimulus(0, 0, 1, 1, 1, 10'd7);     checkOutput("abs_over_rel", 10'd7);
        applyStimulus(0, 0, 0, 1, 1, 10'h3FF);   checkOutput("rel_minus_one", 10'd6);
        applyStimulus(0, 0, 1, 0, 0, 10'd16);    checkOutput("abs_to_16", 10'd16);
        applyStimulus(1, 0, 0, 0, 0, 10'd0);     checkOutput("mid_reset", 10'd0);
        applyStimulus(0, 0, 0, 0, 0, 10'd0);     checkOutput("idle_after_reset", 10'd0);
        applyStimulus(0, 1, 0, 0, 0, 10'd0);     checkOutput("rearm", 10'd0);
        applyStimulus(0, 0, 0, 0, 0, 10'd0);     checkOutput("relaunch", 10'd0);
        applyStimulus(0, 0, 0, 0, 0, 10'd0);     checkOutput("run_step_1", 10'd1);
        applyStimulus(0, 0, 0, 0, 0, 10'd0);     checkOutput("run_step_2", 10'd2);
        applyStimulus(0, 1, 0, 0, 0, 10'd0);     checkOutput("restart_hold_1", 10'd2);
        applyStimulus(0, 1, 1, 0, 0, 10'd9);     checkOutput("restart_hold_2", 10'd2);
        applyStimulus(0, 1, 0, 0, 0, 10'd0);     checkOutput("restart_hold_3", 10'd2);
        applyStimulus(0, 0, 0, 0, 0, 10'd0);     checkOutput("restart_launch", 10'd0);
        applyStimulus(0, 0, 0, 0, 0, 10'd0);     checkOutput("restart_step", 10'd1);
        applyStimulus(0, 0, 0, 1, 1, 10'd4);     checkOutput("rel_after_restart", 10'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
